uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single transmit side of the buffered UART (`buart`) between two byte producers: port 0 (Forth core `emit`) and port 1 (hardware status/echo source). Each port has its own small byte FIFO; a round-robin scheduler with per-port lock moves bytes into the UART one at a time, honouring its `busy` flag. Sits between the producers and `buart`'s `wr`/`tx_data`/`busy` pins; the UART receive path is untouched.

## Interface

- `DEPTH`, 4, per-port FIFO depth in bytes; power of two, ≥2.
- `LOCK_TIMEOUT`, 1024, idle cycles after which a held lock is forcibly released.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_wr`  in  1  port 0 write strobe, one byte per high cycle.
- `req0_data`  in  8  port 0 byte.
- `req0_lock`  in  1  port 0 requests exclusive grant (keeps multi-byte messages contiguous).
- `req0_full`  out  1  port 0 FIFO holds `DEPTH` bytes.
- `req1_wr`, `req1_data`, `req1_lock`, `req1_full`: same for port 1.
- `uart_wr`  out  1  one-cycle write pulse to `buart.wr`.
- `uart_data`  out  8  byte to `buart.tx_data`, valid while `uart_wr` high.
- `uart_busy`  in  1  `buart.busy`.
- `grant`  out  1  port of the byte currently or last sent.
- `active`  out  1  high in SEND and DRAIN.

## Operation

- FIFOs: pointers `$clog2(DEPTH)+1` bits wide, wrap modulo 2·DEPTH; full when pointers differ only in MSB; empty when equal. Write accepted only when `reqN_wr` high and `reqN_full` low at that edge; writes while full are dropped. A pop in the same cycle does not make room for a same-cycle write. Push to an empty FIFO while the arbiter idles is legal.
- States: IDLE, SEND, DRAIN.
- IDLE: if `uart_busy` low and a candidate port is non-empty, pop its head into `uart_data`, set `uart_wr`, `grant` = port, go SEND. Otherwise stay.
- Candidate selection: if `locked` is set, only `grant` is eligible. Else if both ports are non-empty, pick `~grant`; else pick the non-empty port.
- SEND: `uart_wr` high for exactly this cycle; go DRAIN. `locked` <= `reqN_lock` of the granted port.
- DRAIN: `uart_wr` low; stay while `uart_busy` high; go IDLE when low.
- Lock release: `locked` clears when the owner's `lock` is low in IDLE, or when the timeout counter reaches `LOCK_TIMEOUT`. The counter is `$clog2(LOCK_TIMEOUT+1)` bits, increments each IDLE cycle with `locked` set and owner FIFO empty, and clears on any SEND or on lock release. It saturates, no wrap.
- While `locked`, the other port still accepts writes up to full.

## Timing

- Reset values: `uart_wr`=0, `uart_data`=0, `grant`=0, `active`=0, `req0_full`=`req1_full`=0, `locked`=0, both FIFOs empty, state IDLE.
- `uart_wr`, `uart_data`, `grant`, `active` are registered outputs. `reqN_full` derives from registered pointers.
- Latency: `reqN_wr` in cycle 0 into an empty FIFO with the arbiter idle and `uart_busy` low gives `uart_wr` high in cycle 2.
- `buart` raises `busy` the cycle after `uart_wr`, so DRAIN's first cycle always sees busy high. The post-reset `buart` dummy period holds the arbiter in IDLE.
- Minimum spacing between `uart_wr` pulses: SEND + DRAIN (≥ one UART frame) + 1 IDLE cycle.
- Reset asserted mid-SEND/DRAIN: `uart_wr` drops asynchronously and queued bytes are discarded. A byte already handed to `buart` is its own concern.

## Test plan

- Single byte: `req0` writes 0x41 at cycle 0, `uart_busy` low → `uart_wr`=1 with `uart_data`=0x41 in cycle 2 only; `active` high until `uart_busy` falls.
- Round-robin: both ports preloaded, port 0 with 0x10,0x11 and port 1 with 0x20,0x21, no lock → UART order 0x20,0x10,0x21,0x11 (reset `grant`=0 so port 1 wins first).
- Lock: port 0 `lock` high, sends 0x30,0x31,0x32 while port 1 holds 0x40 → 0x40 appears only after port 0 drops `lock`. Repeat with `lock` stuck high and FIFO empty → 0x40 sent after exactly `LOCK_TIMEOUT` idle cycles.
- Full/overflow: with `uart_busy` forced high, write DEPTH+2 bytes 0x00..0x05 to port 1 → `req1_full` high after the 4th write; bytes 0x00..0x03 are sent after busy releases and 0x04, 0x05 are lost.
- Pointer wrap: stream 3·DEPTH bytes through one port → all are sent in order with no duplicates.
- Async reset during DRAIN with both FIFOs non-empty → all outputs return to reset values immediately; no `uart_wr` until new writes arrive.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the buart transmit pins between two byte producers.
// Each producer owns a small byte FIFO. A round-robin scheduler with an
// optional per-port lock hands one byte at a time to the UART. It waits for
// the UART's busy flag to clear before it hands over the next byte.
module uart_tx_arbiter #(
    parameter int DEPTH        = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_wr,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    output logic       req0_full,
    input  logic       req1_wr,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic       req1_full,
    output logic       uart_wr,
    output logic [7:0] uart_data,
    input  logic       uart_busy,
    output logic       grant,
    output logic       active
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    // Pointers differing only in the MSB mean the FIFO has wrapped once: full.
    localparam logic [PW-1:0] PTR_FULL_XOR = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] CNT_MAX      = CW'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [7:0]    r_mem  [2][DEPTH];
    logic [PW-1:0] r_wptr [2];
    logic [PW-1:0] r_rptr [2];

    state_t        r_state;
    logic          r_uart_wr;
    logic [7:0]    r_uart_data;
    logic          r_grant;
    logic          r_active;
    logic          r_locked;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_wr;
    logic [1:0]    w_lock;
    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [7:0]    w_data [2];
    logic [7:0]    w_head [2];
    logic          w_timeout;
    logic          w_lock_eff;
    logic          w_cand;
    logic          w_cand_ok;
    logic          w_start;

    assign req0_full = w_full[0];
    assign req1_full = w_full[1];
    assign uart_wr   = r_uart_wr;
    assign uart_data = r_uart_data;
    assign grant     = r_grant;
    assign active    = r_active;

    // FIFO status, push qualification and head-of-queue bytes for both ports.
    always_comb begin
        w_wr      = {req1_wr, req0_wr};
        w_lock    = {req1_lock, req0_lock};
        w_data[0] = req0_data;
        w_data[1] = req1_data;
        w_full    = 2'b00;
        w_empty   = 2'b00;
        w_push    = 2'b00;
        for (int p = 0; p < 2; p++) begin
            w_full[p]  = ((r_wptr[p] ^ r_rptr[p]) == PTR_FULL_XOR);
            w_empty[p] = (r_wptr[p] == r_rptr[p]);
            // Full is judged on the registered pointers, so a same-cycle pop
            // never frees room for a same-cycle write.
            w_push[p]  = w_wr[p] & ~w_full[p];
            w_head[p]  = r_mem[p][r_rptr[p][AW-1:0]];
        end
    end

    // Candidate selection: the lock owner alone is eligible; otherwise alternate.
    always_comb begin
        w_timeout  = (r_cnt == CNT_MAX);
        // A lock dropped or timed out this cycle already stops restricting choice.
        w_lock_eff = r_locked & w_lock[r_grant] & ~w_timeout;
        w_cand     = r_grant;
        w_cand_ok  = 1'b0;
        if (w_lock_eff) begin
            w_cand    = r_grant;
            w_cand_ok = ~w_empty[r_grant];
        end else if (~w_empty[0] & ~w_empty[1]) begin
            w_cand    = ~r_grant;
            w_cand_ok = 1'b1;
        end else if (~w_empty[0]) begin
            w_cand    = 1'b0;
            w_cand_ok = 1'b1;
        end else if (~w_empty[1]) begin
            w_cand    = 1'b1;
            w_cand_ok = 1'b1;
        end else begin
            w_cand    = r_grant;
            w_cand_ok = 1'b0;
        end
        w_start  = (r_state == S_IDLE) & ~uart_busy & w_cand_ok;
        w_pop[0] = w_start & ~w_cand;
        w_pop[1] = w_start & w_cand;
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
                r_mem[p][r_wptr[p][AW-1:0]] <= w_data[p];
            end
        end
    end

    // FIFO pointers: modulo 2*DEPTH so that full and empty can be told apart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                r_wptr[p] <= {PW{1'b0}};
                r_rptr[p] <= {PW{1'b0}};
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) begin
                    r_wptr[p] <= r_wptr[p] + PW'(1);
                end
                if (w_pop[p]) begin
                    r_rptr[p] <= r_rptr[p] + PW'(1);
                end
            end
        end
    end

    // Arbiter FSM with registered UART strobe/data, grant, activity and lock state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_uart_wr   <= 1'b0;
            r_uart_data <= 8'h00;
            r_grant     <= 1'b0;
            r_active    <= 1'b0;
            r_locked    <= 1'b0;
            r_cnt       <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_uart_wr <= 1'b0;
                    // Lock is released by the owner or by the starvation guard.
                    if (r_locked && (!w_lock[r_grant] || w_timeout)) begin
                        r_locked <= 1'b0;
                        r_cnt    <= {CW{1'b0}};
                    end else if (r_locked && w_empty[r_grant] && (r_cnt != CNT_MAX)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                    if (w_start) begin
                        r_state     <= S_SEND;
                        r_uart_wr   <= 1'b1;
                        r_uart_data <= w_head[w_cand];
                        r_grant     <= w_cand;
                        r_active    <= 1'b1;
                        r_cnt       <= {CW{1'b0}};
                    end
                end
                S_SEND: begin
                    r_uart_wr <= 1'b0;
                    r_state   <= S_DRAIN;
                    r_locked  <= w_lock[r_grant];
                    r_cnt     <= {CW{1'b0}};
                end
                S_DRAIN: begin
                    r_uart_wr <= 1'b0;
                    if (!uart_busy) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_uart_wr <= 1'b0;
                    r_active  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed traffic on both ports, a
// simple buart busy model, and a monitor that checks every UART write
// against the queue of expected {port, byte} values.
module tb_uart_tx_arbiter;

    localparam int LT    = 1024;
    localparam int FRAME = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_wr, req0_lock, req1_wr, req1_lock;
    logic [7:0] req0_data, req1_data;
    logic       req0_full, req1_full;
    logic       uart_wr;
    logic [7:0] uart_data;
    logic       uart_busy;
    logic       grant, active;

    logic       force_busy;
    int         busy_cnt = 0;

    logic [8:0] sb_q [$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         n_sent = 0;

    uart_tx_arbiter #(.DEPTH(4), .LOCK_TIMEOUT(LT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_wr   (req0_wr),
        .req0_data (req0_data),
        .req0_lock (req0_lock),
        .req0_full (req0_full),
        .req1_wr   (req1_wr),
        .req1_data (req1_data),
        .req1_lock (req1_lock),
        .req1_full (req1_full),
        .uart_wr   (uart_wr),
        .uart_data (uart_data),
        .uart_busy (uart_busy),
        .grant     (grant),
        .active    (active)
    );

    always #5 clk = ~clk;

    // buart stand-in: busy rises the cycle after a write and lasts FRAME cycles.
    always @(posedge clk) begin
        if (uart_wr) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy = force_busy | (busy_cnt != 0);

    // Monitor: every UART write must match the oldest expected entry.
    always @(negedge clk) begin
        logic [8:0] exp_v;
        if (uart_wr === 1'b1) begin
            n_sent = n_sent + 1;
            n_cmp  = n_cmp + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL uart_unexpected: got port %0d byte 0x%02h, required no write",
                         grant, uart_data);
            end else begin
                exp_v = sb_q.pop_front();
                if ({grant, uart_data} !== exp_v) begin
                    n_fail = n_fail + 1;
                    $display("FAIL uart_byte: got port %0d byte 0x%02h, required port %0d byte 0x%02h",
                             grant, uart_data, exp_v[8], exp_v[7:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (active !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'd0, active}, 32'd0);
    endtask

    task automatic wait_sent(input string nm, input int base);
        int n = 0;
        while (n_sent == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(nm, (n_sent > base) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sb_q.size() != 0 || active !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(nm, sb_q.size(), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        reset      = 1'b1;
        force_busy = 1'b0;
        req0_wr = 1'b0; req0_lock = 1'b0; req0_data = 8'h00;
        req1_wr = 1'b0; req1_lock = 1'b0; req1_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_uart_wr",   {31'd0, uart_wr},   32'd0);
        check("rst_uart_data", {24'd0, uart_data}, 32'd0);
        check("rst_grant",     {31'd0, grant},     32'd0);
        check("rst_active",    {31'd0, active},    32'd0);
        check("rst_full0",     {31'd0, req0_full}, 32'd0);
        check("rst_full1",     {31'd0, req1_full}, 32'd0);

        // Single byte: write in cycle 0, strobe in cycle 2 only
        sb_q.push_back({1'b0, 8'h41});
        req0_wr = 1'b1; req0_data = 8'h41;
        @(negedge clk);
        req0_wr = 1'b0;
        check("t1_cycle1_wr", {31'd0, uart_wr}, 32'd0);
        @(negedge clk);
        check("t1_cycle2_wr", {31'd0, uart_wr}, 32'd1);
        check("t1_cycle2_act", {31'd0, active}, 32'd1);
        @(negedge clk);
        check("t1_cycle3_wr", {31'd0, uart_wr}, 32'd0);
        check("t1_cycle3_act", {31'd0, active}, 32'd1);
        check("t1_drain_busy", {31'd0, uart_busy}, 32'd1);
        wait_idle("t1_idle");
        check("t1_idle_busy", {31'd0, uart_busy}, 32'd0);
        drain("t1_drain");

        // Round-robin: grant=0 so port 1 goes first
        force_busy = 1'b1;
        req0_wr = 1'b1; req0_data = 8'h10; req1_wr = 1'b1; req1_data = 8'h20;
        @(negedge clk);
        req0_data = 8'h11; req1_data = 8'h21;
        @(negedge clk);
        req0_wr = 1'b0; req1_wr = 1'b0;
        sb_q.push_back({1'b1, 8'h20});
        sb_q.push_back({1'b0, 8'h10});
        sb_q.push_back({1'b1, 8'h21});
        sb_q.push_back({1'b0, 8'h11});
        repeat (3) @(negedge clk);
        check("t2_held_by_busy", n_sent, 32'd1);
        force_busy = 1'b0;
        drain("t2_drain");

        // Lock held by port 0: port 1's byte waits until the lock drops
        req0_lock = 1'b1;
        sb_q.push_back({1'b0, 8'h30});
        sb_q.push_back({1'b0, 8'h31});
        sb_q.push_back({1'b0, 8'h32});
        req0_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_data = 8'h30 + 8'(i);
            @(negedge clk);
        end
        req0_wr = 1'b0;
        req1_wr = 1'b1; req1_data = 8'h40;
        @(negedge clk);
        req1_wr = 1'b0;
        drain("t3_locked_drain");
        base = n_sent;
        repeat (50) @(negedge clk);
        check("t3_lock_holds", n_sent, base);
        sb_q.push_back({1'b1, 8'h40});
        req0_lock = 1'b0;
        drain("t3_release_drain");

        // Lock stuck high with empty owner FIFO: released by the timeout
        req0_lock = 1'b1;
        sb_q.push_back({1'b0, 8'h50});
        base = n_sent;
        req0_wr = 1'b1; req0_data = 8'h50;
        @(negedge clk);
        req0_wr = 1'b0;
        req1_wr = 1'b1; req1_data = 8'h42;
        @(negedge clk);
        req1_wr = 1'b0;
        wait_sent("t4_owner_sent", base);
        wait_idle("t4_idle");
        // LT counted idle cycles, then the release cycle, then the strobe
        sb_q.push_back({1'b1, 8'h42});
        n = 0;
        while (uart_wr !== 1'b1 && n < LT + 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_cycles", n, LT + 1);
        req0_lock = 1'b0;
        drain("t4_drain");

        // Full/overflow on port 1 with the UART held busy
        force_busy = 1'b1;
        req1_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req1_data = 8'(i);
            @(negedge clk);
            check($sformatf("t5_full_after_%0d", i + 1), {31'd0, req1_full},
                  (i >= 3) ? 32'd1 : 32'd0);
        end
        req1_wr = 1'b0;
        for (int i = 0; i < 4; i++) sb_q.push_back({1'b1, 8'(i)});
        force_busy = 1'b0;
        drain("t5_drain");
        check("t5_full_clear", {31'd0, req1_full}, 32'd0);

        // Pointer wrap: 3*DEPTH bytes through port 0, pacing on req0_full
        for (int i = 0; i < 12; i++) begin
            n = 0;
            while (req0_full === 1'b1 && n < 500) begin
                req0_wr = 1'b0;
                @(negedge clk);
                n++;
            end
            req0_wr = 1'b1; req0_data = 8'h80 + 8'(i);
            sb_q.push_back({1'b0, 8'h80 + 8'(i)});
            @(negedge clk);
        end
        req0_wr = 1'b0;
        drain("t6_drain");

        // Async reset during DRAIN with both FIFOs holding bytes
        sb_q.push_back({1'b0, 8'h60});
        base = n_sent;
        req0_wr = 1'b1; req0_data = 8'h60;
        @(negedge clk);
        req0_wr = 1'b0;
        wait_sent("t7_first_sent", base);
        req0_wr = 1'b1; req0_data = 8'h61; req1_wr = 1'b1; req1_data = 8'h70;
        @(negedge clk);
        req0_wr = 1'b0; req1_wr = 1'b0;
        check("t7_in_drain", {31'd0, active}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_wr",     {31'd0, uart_wr},   32'd0);
        check("t7_rst_data",   {24'd0, uart_data}, 32'd0);
        check("t7_rst_grant",  {31'd0, grant},     32'd0);
        check("t7_rst_active", {31'd0, active},    32'd0);
        check("t7_rst_full0",  {31'd0, req0_full}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base = n_sent;
        repeat (40) @(negedge clk);
        check("t7_no_stale_send", n_sent, base);
        sb_q.push_back({1'b1, 8'h77});
        req1_wr = 1'b1; req1_data = 8'h77;
        @(negedge clk);
        req1_wr = 1'b0;
        drain("t7_drain");

        check("final_queue_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
